double_sensitive_clock: RTL and testbench

Dual-edge data register: samples `d` on both the rising and the falling edge of `clk` and presents the most recent sample on `out`. It doubles the effective capture rate without a 2x clock. It is built from standard single-edge flops (XOR dual-edge scheme), not from a process sensitive to both edges, so it stays synthesizable. It sits at the edge of a datapath that needs half-cycle sampling, for example DDR-style capture.

---
 rtl/dsc_pkg.sv | 11 +
 rtl/dsc_edge_reg.sv | 43 ++++
 rtl/double_sensitive_clock.sv | 78 +++++++
 tb/tb_double_sensitive_clock.sv | 128 ++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared constants and types for the dual-edge data register.
// Optional change detection is enabled with DSC_CHANGE_DET_EN.
`timescale 1ns/1ps
package dsc_pkg;

  localparam int DSC_DEFAULT_WIDTH = 1;
  localparam logic DSC_RESET_VAL = 1'b0;

  typedef logic [DSC_DEFAULT_WIDTH-1:0] dsc_data_t;

endpackage

// File: rtl/dsc_edge_reg.sv
// Single-edge half of an XOR dual-edge register pair.
// NEG_EDGE selects the active clock edge; reset is async active-low.
`timescale 1ns/1ps
module dsc_edge_reg
  import dsc_pkg::*;
#(
  parameter int WIDTH    = DSC_DEFAULT_WIDTH,
  parameter bit NEG_EDGE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] other_q_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Storing d ^ other lets the pair's XOR reproduce d.
  assign q_d = d_i ^ other_q_i;

  if (NEG_EDGE) begin : g_neg
    always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q_q <= {WIDTH{DSC_RESET_VAL}};
      end else begin
        q_q <= q_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q_q <= {WIDTH{DSC_RESET_VAL}};
      end else begin
        q_q <= q_d;
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/double_sensitive_clock.sv
// Dual-edge data register built from two single-edge flop banks.
// Define DSC_CHANGE_DET_EN to add the `changed` output.
`timescale 1ns/1ps
module double_sensitive_clock
  import dsc_pkg::*;
#(
  parameter int WIDTH = DSC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out
`ifdef DSC_CHANGE_DET_EN
  ,
  output logic             changed
`endif
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_f;

  dsc_edge_reg #(
    .WIDTH    (WIDTH),
    .NEG_EDGE (1'b0)
  ) u_data_r (
    .clk_i     (clk),
    .rst_ni    (reset),
    .d_i       (d),
    .other_q_i (q_f),
    .q_o       (q_r)
  );

  dsc_edge_reg #(
    .WIDTH    (WIDTH),
    .NEG_EDGE (1'b1)
  ) u_data_f (
    .clk_i     (clk),
    .rst_ni    (reset),
    .d_i       (d),
    .other_q_i (q_r),
    .q_o       (q_f)
  );

  assign out = q_r ^ q_f;

`ifdef DSC_CHANGE_DET_EN
  logic [WIDTH-1:0] h_r;
  logic [WIDTH-1:0] h_f;
  logic [WIDTH-1:0] prev;

  // History pair captures `out` as it stood just before each edge.
  dsc_edge_reg #(
    .WIDTH    (WIDTH),
    .NEG_EDGE (1'b0)
  ) u_hist_r (
    .clk_i     (clk),
    .rst_ni    (reset),
    .d_i       (out),
    .other_q_i (h_f),
    .q_o       (h_r)
  );

  dsc_edge_reg #(
    .WIDTH    (WIDTH),
    .NEG_EDGE (1'b1)
  ) u_hist_f (
    .clk_i     (clk),
    .rst_ni    (reset),
    .d_i       (out),
    .other_q_i (h_r),
    .q_o       (h_f)
  );

  assign prev    = h_r ^ h_f;
  assign changed = |(out ^ prev);
`endif

endmodule

// File: tb/tb_double_sensitive_clock.sv
// Directed bench for double_sensitive_clock on a 10 ns clock.
// Checks `changed` too when DSC_CHANGE_DET_EN is defined.
`timescale 1ns/1ps
module tb_double_sensitive_clock;

  logic       clk;
  logic       reset;
  logic [0:0] d;
  logic [0:0] out;
`ifdef DSC_CHANGE_DET_EN
  logic       changed;
`endif

  int passed;
  int total;

  double_sensitive_clock #(
    .WIDTH (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .out     (out)
`ifdef DSC_CHANGE_DET_EN
    ,
    .changed (changed)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic at(input int t);
    int now;
    now = int'($time);
    if (t > now) #(t - now);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at %0t: observed %b expected %b",
                tag, $time, obs, exp);
  endtask

  task automatic check_chg(input string tag, input logic exp);
`ifdef DSC_CHANGE_DET_EN
    check(tag, changed, exp);
`else
    if (exp !== exp) $display("unused %s", tag);
`endif
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    d      = 1'b1;

    // reset hold with d toggling
    at(7);   check("rst_hold_a", out, 1'b0);
    check_chg("rst_chg_a", 1'b0);
    at(8);   d = 1'b0;
    at(11);  d = 1'b1;
    reset = 1'b1;
    at(12);  check("rst_hold_b", out, 1'b0);

    // rising-edge capture, then falling-edge overwrite
    d = 1'b1;
    at(14);  check("no_cap_yet", out, 1'b0);
    at(17);  check("rise_cap_1", out, 1'b1);
    check_chg("chg_rise_1", 1'b1);
    at(18);  d = 1'b0;
    at(22);  check("fall_cap_0", out, 1'b0);
    check_chg("chg_fall_0", 1'b1);
    at(27);  check("steady_0", out, 1'b0);
    check_chg("chg_steady_0", 1'b0);

    // asynchronous reset between edges
    at(26);  d = 1'b1;
    at(31);  check("pre_async", out, 1'b1);
    at(32);  reset = 1'b0;
    #0.5;    check("async_rst", out, 1'b0);
    check_chg("async_chg", 1'b0);
    at(37);  check("rst_edge_hold", out, 1'b0);

    // release: next edge (falling @40) is first capture
    at(38);  reset = 1'b1;
    at(39);  check("post_rel", out, 1'b0);
    at(42);  check("first_cap", out, 1'b1);
    check_chg("first_cap_chg", 1'b1);
    at(47);  check("hold_1_r", out, 1'b1);
    check_chg("steady1_chg_r", 1'b0);
    at(52);  check("hold_1_f", out, 1'b1);
    check_chg("steady1_chg_f", 1'b0);

    // capture around rising 65 / falling 70
    at(53);  d = 1'b0;
    at(57);  check("drop_0", out, 1'b0);
    at(63);  d = 1'b1;
    at(64);  check("pre_65", out, 1'b0);
    at(67);  check("cap_65", out, 1'b1);
    at(68);  d = 1'b0;
    at(72);  check("cap_70", out, 1'b0);

    // double-rate stream: d set 2 ns after each edge
    for (int k = 0; k < 8; k++) begin
      at(72 + 5 * k);
      d = (k % 2 == 0) ? 1'b1 : 1'b0;
      at(76 + 5 * k);
      check($sformatf("stream_%0d", k), out,
            (k % 2 == 0) ? 1'b1 : 1'b0);
      check_chg($sformatf("stream_chg_%0d", k), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
